// File: rtl/cpu_busctl_if.sv
// Bus bundle between the MCS8 bus controller, the 8008 core pins and the
// request/acknowledge memory/IO slave port.
interface cpu_busctl_if;
    logic        SYNC_I;
    logic [2:0]  STATE_I;
    logic [7:0]  CPU_DAT_I;
    logic [7:0]  CPU_DAT_O;
    logic        READY_O;
    logic        HALT_O;
    logic [7:0]  INT_INSTR_I;
    logic        INTA_O;
    logic [13:0] MEM_ADDR_O;
    logic [7:0]  MEM_DAT_O;
    logic [7:0]  MEM_DAT_I;
    logic        MEM_RD_O;
    logic        MEM_WR_O;
    logic        IO_RD_O;
    logic        IO_WR_O;
    logic [4:0]  IO_PORT_O;
    logic        MEM_ACK_I;
    logic        ERR_O;

    // Controller view
    modport master (
        input  SYNC_I, STATE_I, CPU_DAT_I, INT_INSTR_I, MEM_DAT_I, MEM_ACK_I,
        output CPU_DAT_O, READY_O, HALT_O, INTA_O, MEM_ADDR_O, MEM_DAT_O,
               MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O, IO_PORT_O, ERR_O
    );

    // Core/slave/system view
    modport slave (
        output SYNC_I, STATE_I, CPU_DAT_I, INT_INSTR_I, MEM_DAT_I, MEM_ACK_I,
        input  CPU_DAT_O, READY_O, HALT_O, INTA_O, MEM_ADDR_O, MEM_DAT_O,
               MEM_RD_O, MEM_WR_O, IO_RD_O, IO_WR_O, IO_PORT_O, ERR_O
    );
endinterface

// File: rtl/cpu_busctl.sv
// MCS8 system bus controller: demultiplexes the 8008 bus, runs memory/IO
// cycles on a req/ack slave port, paces the core via READY, times out hangs.
module cpu_busctl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic         CLK_I,
    input  logic         nRST_I,
    cpu_busctl_if.master bus
);
    localparam int unsigned AW = 14;
    localparam int unsigned DW = 8;
    localparam int unsigned HW = 6;
    localparam int unsigned CNTW = 8;
    localparam logic [CNTW-1:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

    localparam logic [2:0] ST_T1   = 3'b010;
    localparam logic [2:0] ST_T2   = 3'b100;
    localparam logic [2:0] ST_T3   = 3'b001;
    localparam logic [2:0] ST_T1I  = 3'b110;
    localparam logic [2:0] ST_STOP = 3'b011;

    localparam logic [1:0] CYC_PCI = 2'b00;
    localparam logic [1:0] CYC_PCC = 2'b01;
    localparam logic [1:0] CYC_PCR = 2'b10;
    localparam logic [1:0] CYC_PCW = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_WAIT,
        S_IO_WAIT,
        S_WR_PEND,
        S_WR_WAIT,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [DW-1:0]   addr_l_q, addr_l_d;
    logic [HW-1:0]   addr_h_q, addr_h_d;
    logic [1:0]      cyc_q, cyc_d;
    logic            int_pend_q, int_pend_d;
    logic            pend_q, pend_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_dat_q, mem_dat_d;
    logic            mem_rd_q, mem_rd_d;
    logic            mem_wr_q, mem_wr_d;
    logic            io_rd_q, io_rd_d;
    logic            io_wr_q, io_wr_d;
    logic            ready_q, ready_d;
    logic            inta_q, inta_d;
    logic            err_q, err_d;
    logic            rd_cyc_q, rd_cyc_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic t1_s, t1i_s, t2_s, t3_s;
    logic do_disp;

    assign t1i_s = bus.SYNC_I && (bus.STATE_I == ST_T1I);
    assign t1_s  = (bus.SYNC_I && (bus.STATE_I == ST_T1)) || t1i_s;
    assign t2_s  = bus.SYNC_I && (bus.STATE_I == ST_T2);
    assign t3_s  = bus.SYNC_I && (bus.STATE_I == ST_T3);

    always_ff @(posedge CLK_I or negedge nRST_I) begin
        if (!nRST_I) begin
            state_q    <= S_IDLE;
            addr_l_q   <= '0;
            addr_h_q   <= '0;
            cyc_q      <= '0;
            int_pend_q <= 1'b0;
            pend_q     <= 1'b0;
            rdata_q    <= '0;
            mem_addr_q <= '0;
            mem_dat_q  <= '0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            io_rd_q    <= 1'b0;
            io_wr_q    <= 1'b0;
            ready_q    <= 1'b1;
            inta_q     <= 1'b0;
            err_q      <= 1'b0;
            rd_cyc_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_l_q   <= addr_l_d;
            addr_h_q   <= addr_h_d;
            cyc_q      <= cyc_d;
            int_pend_q <= int_pend_d;
            pend_q     <= pend_d;
            rdata_q    <= rdata_d;
            mem_addr_q <= mem_addr_d;
            mem_dat_q  <= mem_dat_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            io_rd_q    <= io_rd_d;
            io_wr_q    <= io_wr_d;
            ready_q    <= ready_d;
            inta_q     <= inta_d;
            err_q      <= err_d;
            rd_cyc_q   <= rd_cyc_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_l_d   = addr_l_q;
        addr_h_d   = addr_h_q;
        cyc_d      = cyc_q;
        int_pend_d = int_pend_q;
        pend_d     = pend_q;
        rdata_d    = rdata_q;
        mem_addr_d = mem_addr_q;
        mem_dat_d  = mem_dat_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        io_rd_d    = io_rd_q;
        io_wr_d    = io_wr_q;
        ready_d    = ready_q;
        inta_d     = 1'b0;
        err_d      = err_q;
        rd_cyc_d   = rd_cyc_q;
        cnt_d      = cnt_q;
        do_disp    = 1'b0;

        // Address staging runs regardless of state; the bus address is
        // snapshotted at dispatch so an in-flight write is not disturbed.
        if (t1_s) addr_l_d = bus.CPU_DAT_I;
        if (t1i_s) int_pend_d = 1'b1;
        if (t2_s) begin
            addr_h_d = bus.CPU_DAT_I[5:0];
            cyc_d    = bus.CPU_DAT_I[7:6];
        end

        case (state_q)
            S_IDLE: begin
                if (t2_s) do_disp = 1'b1;
            end
            S_DONE: begin
                if (t2_s) do_disp = 1'b1;
                else if (t1_s) state_d = S_IDLE;
            end
            S_WR_PEND: begin
                if (t3_s) begin
                    mem_dat_d = bus.CPU_DAT_I;
                    mem_wr_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WR_WAIT;
                end
            end
            S_RD_WAIT, S_IO_WAIT, S_WR_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (t2_s && (state_q == S_WR_WAIT)) begin
                    pend_d  = 1'b1;
                    ready_d = 1'b0;
                end
                // Ack has priority over a coincident timeout
                if (bus.MEM_ACK_I || (cnt_q == CNT_LAST)) begin
                    mem_rd_d = 1'b0;
                    mem_wr_d = 1'b0;
                    io_rd_d  = 1'b0;
                    io_wr_d  = 1'b0;
                    if (bus.MEM_ACK_I) begin
                        if (state_q != S_WR_WAIT) rdata_d = bus.MEM_DAT_I;
                    end else begin
                        rdata_d = 8'hFF;
                        err_d   = 1'b1;
                    end
                    state_d = S_DONE;
                    ready_d = 1'b1;
                    if ((state_q == S_WR_WAIT) && (pend_q || t2_s)) begin
                        do_disp = 1'b1;
                        pend_d  = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Cycle dispatch from the latched T2 byte (live or held off)
        if (do_disp) begin
            mem_addr_d = {addr_h_d, addr_l_q};
            rd_cyc_d   = 1'b0;
            cnt_d      = '0;
            case (cyc_d)
                CYC_PCI, CYC_PCR: begin
                    if ((cyc_d == CYC_PCI) && int_pend_q) begin
                        rdata_d    = bus.INT_INSTR_I;
                        inta_d     = 1'b1;
                        int_pend_d = 1'b0;
                        rd_cyc_d   = 1'b1;
                        ready_d    = 1'b1;
                        state_d    = S_DONE;
                    end else begin
                        mem_rd_d = 1'b1;
                        rd_cyc_d = 1'b1;
                        ready_d  = 1'b0;
                        state_d  = S_RD_WAIT;
                    end
                end
                CYC_PCC: begin
                    ready_d = 1'b0;
                    state_d = S_IO_WAIT;
                    if (addr_h_d[5:4] == 2'b00) begin
                        io_rd_d  = 1'b1;
                        rd_cyc_d = 1'b1;
                    end else begin
                        mem_dat_d = addr_l_q;
                        io_wr_d   = 1'b1;
                    end
                end
                CYC_PCW: begin
                    ready_d = 1'b1;
                    state_d = S_WR_PEND;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign bus.CPU_DAT_O  = ((bus.STATE_I == ST_T3) && (state_q == S_DONE) && rd_cyc_q)
                            ? rdata_q : 8'h00;
    assign bus.HALT_O     = (bus.STATE_I == ST_STOP);
    assign bus.READY_O    = ready_q;
    assign bus.INTA_O     = inta_q;
    assign bus.MEM_ADDR_O = mem_addr_q;
    assign bus.MEM_DAT_O  = mem_dat_q;
    assign bus.MEM_RD_O   = mem_rd_q;
    assign bus.MEM_WR_O   = mem_wr_q;
    assign bus.IO_RD_O    = io_rd_q;
    assign bus.IO_WR_O    = io_wr_q;
    assign bus.IO_PORT_O  = mem_addr_q[13:9];
    assign bus.ERR_O      = err_q;
endmodule
